// File: rtl/min_drain_pkg.sv
// rtl/min_drain_pkg.sv - shared state enum, defaults and one-hot helper for min_drain_scheduler
package min_drain_pkg;

    localparam int DEF_DATA_WIDTH    = 8;
    localparam int DEF_CHANNEL_COUNT = 6;
    localparam int MAX_CHANNELS      = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Isolates the lowest set bit, so ties resolve to the lowest channel index.
    function automatic logic [MAX_CHANNELS-1:0] lowest_set_onehot(
        input logic [MAX_CHANNELS-1:0] bits
    );
        return bits & (~bits + MAX_CHANNELS'(1));
    endfunction

endpackage

// File: rtl/min_drain_scheduler_min_val.sv
// rtl/min_drain_scheduler_min_val.sv - combinational minimum finder flagging every valid channel holding the minimum
module min_val_less_8x_with_index #(
    parameter int DATA_WIDTH    = 8,
    parameter int CHANNEL_COUNT = 6
) (
    input  logic [DATA_WIDTH*CHANNEL_COUNT-1:0] values,
    input  logic [CHANNEL_COUNT-1:0]            valids,
    output logic [DATA_WIDTH-1:0]               min_value,
    output logic [CHANNEL_COUNT-1:0]            output_valids
);

    logic found;

    always_comb begin
        min_value = '1;
        found     = 1'b0;
        for (int i = 0; i < CHANNEL_COUNT; i++) begin
            if (valids[i] && (!found || values[i*DATA_WIDTH +: DATA_WIDTH] < min_value)) begin
                min_value = values[i*DATA_WIDTH +: DATA_WIDTH];
                found     = 1'b1;
            end
        end
        output_valids = '0;
        for (int i = 0; i < CHANNEL_COUNT; i++) begin
            output_valids[i] = valids[i] && (values[i*DATA_WIDTH +: DATA_WIDTH] == min_value);
        end
    end

endmodule

// File: rtl/min_drain_scheduler.sv
// rtl/min_drain_scheduler.sv - drains a masked batch smallest-first over valid/ready; MIN_DRAIN_FLUSH_EN adds flush
module min_drain_scheduler
    import min_drain_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int CHANNEL_COUNT = DEF_CHANNEL_COUNT,
    parameter int COUNT_WIDTH   = $clog2(CHANNEL_COUNT + 1)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                load_valid,
    output logic                                load_ready,
    input  logic [DATA_WIDTH*CHANNEL_COUNT-1:0] load_values,
    input  logic [CHANNEL_COUNT-1:0]            load_mask,
    output logic                                grant_valid,
    input  logic                                grant_ready,
    output logic [CHANNEL_COUNT-1:0]            grant_index,
    output logic [DATA_WIDTH-1:0]               grant_value,
    output logic [COUNT_WIDTH-1:0]              grant_count,
`ifdef MIN_DRAIN_FLUSH_EN
    input  logic                                flush,
`endif
    output logic                                done
);

    state_t                              state;
    logic [DATA_WIDTH*CHANNEL_COUNT-1:0] value_reg;
    logic [CHANNEL_COUNT-1:0]            pending;
    logic [DATA_WIDTH-1:0]               min_value;
    logic [CHANNEL_COUNT-1:0]            min_valids;
    logic [CHANNEL_COUNT-1:0]            pick;
    logic                                flush_req;

`ifdef MIN_DRAIN_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    min_val_less_8x_with_index #(
        .DATA_WIDTH    (DATA_WIDTH),
        .CHANNEL_COUNT (CHANNEL_COUNT)
    ) u_min_val (
        .values        (value_reg),
        .valids        (pending),
        .min_value     (min_value),
        .output_valids (min_valids)
    );

    assign pick = CHANNEL_COUNT'(lowest_set_onehot(MAX_CHANNELS'(min_valids)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            load_ready  <= 1'b1;
            value_reg   <= '0;
            pending     <= '0;
            grant_valid <= 1'b0;
            grant_index <= '0;
            grant_value <= '0;
            grant_count <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        value_reg   <= load_values;
                        pending     <= load_mask;
                        grant_count <= '0;
                        load_ready  <= 1'b0;
                        state       <= SCAN;
                    end
                end
                SCAN: begin
                    if (flush_req) begin
                        pending    <= '0;
                        load_ready <= 1'b1;
                        state      <= IDLE;
                    end else if (pending == '0) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        grant_index <= pick;
                        grant_value <= min_value;
                        grant_valid <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Flush outranks a same-cycle handshake; that grant is dropped uncounted.
                    if (flush_req) begin
                        pending     <= '0;
                        grant_valid <= 1'b0;
                        load_ready  <= 1'b1;
                        state       <= IDLE;
                    end else if (grant_ready) begin
                        pending     <= pending & ~grant_index;
                        grant_count <= grant_count + COUNT_WIDTH'(1);
                        grant_valid <= 1'b0;
                        state       <= SCAN;
                    end
                end
                DONE: begin
                    load_ready <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    load_ready <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_min_drain_scheduler.sv
// tb/tb_min_drain_scheduler.sv - scoreboard bench for min_drain_scheduler (flush case under MIN_DRAIN_FLUSH_EN)
module tb_min_drain_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [47:0] load_values = '0;
    logic [5:0]  load_mask = '0;
    logic        grant_valid;
    logic        grant_ready = 1'b0;
    logic [5:0]  grant_index;
    logic [7:0]  grant_value;
    logic [2:0]  grant_count;
    logic        flush = 1'b0;
    logic        done;

    typedef struct { logic [5:0] idx; logic [7:0] val; } gexp_t;
    typedef struct { int cnt; int delta; } dexp_t;

    gexp_t grant_q[$];
    dexp_t done_q[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    load_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    min_drain_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_values (load_values),
        .load_mask   (load_mask),
        .grant_valid (grant_valid),
        .grant_ready (grant_ready),
        .grant_index (grant_index),
        .grant_value (grant_value),
        .grant_count (grant_count),
`ifdef MIN_DRAIN_FLUSH_EN
        .flush       (flush),
`endif
        .done        (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT completes a grant or pulses done.
    always @(negedge clk) begin
        if (load_valid && load_ready) load_cyc = cyc;
        if (!reset && grant_valid && grant_ready && !flush) begin
            if (grant_q.size() == 0) begin
                chk("unexpected_grant", {26'd0, grant_index}, 32'd0);
            end else begin
                gexp_t g;
                g = grant_q.pop_front();
                chk("grant_index", {26'd0, grant_index}, {26'd0, g.idx});
                chk("grant_value", {24'd0, grant_value}, {24'd0, g.val});
            end
        end
        if (!reset && done) begin
            if (done_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                dexp_t d;
                d = done_q.pop_front();
                chk("done_count", {29'd0, grant_count}, d.cnt);
                if (d.delta >= 0) chk("done_latency", cyc - load_cyc, d.delta);
            end
        end
    end

    task automatic do_load(input logic [47:0] vals, input logic [5:0] mask);
        int n = 0;
        while (!load_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("load_ready_wait", {31'd0, load_ready}, 32'd1);
        load_values = vals;
        load_mask   = mask;
        load_valid  = 1'b1;
        @(posedge clk); #1;
        load_valid  = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int gv_seen);
        int n = 0;
        gv_seen = 0;
        do begin
            @(negedge clk);
            if (grant_valid) gv_seen++;
            n++;
        end while (!done && n < budget);
        chk("done_seen", {31'd0, done}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_count(input logic [2:0] n);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (grant_count != n && k < 100);
        chk("count_reached", {29'd0, grant_count}, {29'd0, n});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int gv;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_load_ready", {31'd0, load_ready}, 32'd1);
        chk("rst_grant_valid", {31'd0, grant_valid}, 32'd0);
        chk("rst_grant_index", {26'd0, grant_index}, 32'd0);
        chk("rst_grant_value", {24'd0, grant_value}, 32'd0);
        chk("rst_grant_count", {29'd0, grant_count}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);

        // Ascending drain, ready tied high: done 2N+2 = 14 cycles after load.
        grant_ready = 1'b1;
        grant_q.push_back('{6'b100000, 8'd1});
        grant_q.push_back('{6'b010000, 8'd2});
        grant_q.push_back('{6'b001000, 8'd3});
        grant_q.push_back('{6'b000100, 8'd4});
        grant_q.push_back('{6'b000010, 8'd5});
        grant_q.push_back('{6'b000001, 8'd6});
        done_q.push_back('{6, 14});
        do_load({8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6}, 6'b111111);
        wait_done(100, gv);
        chk("asc_count_hold", {29'd0, grant_count}, 32'd6);

        // Tie on value 7 between ch1 and ch3; smaller masked values ignored.
        grant_q.push_back('{6'b000010, 8'd7});
        grant_q.push_back('{6'b001000, 8'd7});
        done_q.push_back('{2, 6});
        do_load({8'd3, 8'd3, 8'd7, 8'd3, 8'd7, 8'd0}, 6'b001010);
        wait_done(100, gv);

        // Empty batch: done two cycles after load, no grant.
        done_q.push_back('{0, 2});
        do_load({8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1}, 6'b000000);
        wait_done(20, gv);
        chk("empty_no_grant", gv, 32'd0);

        // Backpressure: three stalled cycles, handshake on the fourth.
        grant_ready = 1'b0;
        grant_q.push_back('{6'b000010, 8'd4});
        grant_q.push_back('{6'b000001, 8'd9});
        done_q.push_back('{2, -1});
        do_load({32'd0, 8'd4, 8'd9}, 6'b000011);
        begin
            int k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!grant_valid && k < 20);
        end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_valid", {31'd0, grant_valid}, 32'd1);
            chk("bp_index", {26'd0, grant_index}, 32'b000010);
            chk("bp_value", {24'd0, grant_value}, 32'd4);
            chk("bp_count", {29'd0, grant_count}, 32'd0);
        end
        @(posedge clk); #1 grant_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_count_after", {29'd0, grant_count}, 32'd1);
        wait_done(50, gv);

        // Reset after two of four grants, then a fresh batch.
        grant_q.push_back('{6'b000001, 8'd10});
        grant_q.push_back('{6'b000010, 8'd20});
        do_load({8'd0, 8'd0, 8'd40, 8'd30, 8'd20, 8'd10}, 6'b001111);
        wait_count(3'd2);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_load_ready", {31'd0, load_ready}, 32'd1);
        chk("mid_rst_grant_valid", {31'd0, grant_valid}, 32'd0);
        chk("mid_rst_grant_count", {29'd0, grant_count}, 32'd0);
        chk("mid_rst_grant_index", {26'd0, grant_index}, 32'd0);
        reset = 1'b0;
        grant_q.push_back('{6'b000010, 8'd1});
        grant_q.push_back('{6'b000100, 8'd3});
        grant_q.push_back('{6'b000001, 8'd5});
        done_q.push_back('{3, 8});
        do_load({24'd0, 8'd3, 8'd1, 8'd5}, 6'b000111);
        wait_done(100, gv);

`ifdef MIN_DRAIN_FLUSH_EN
        // Flush together with the third grant handshake.
        grant_q.push_back('{6'b000001, 8'd1});
        grant_q.push_back('{6'b000010, 8'd2});
        do_load({8'd0, 8'd0, 8'd4, 8'd3, 8'd2, 8'd1}, 6'b001111);
        wait_count(3'd2);
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_load_ready", {31'd0, load_ready}, 32'd1);
        chk("flush_grant_valid", {31'd0, grant_valid}, 32'd0);
        chk("flush_grant_count", {29'd0, grant_count}, 32'd2);
        repeat (4) @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        chk("grant_q_empty", grant_q.size(), 32'd0);
        chk("done_q_empty", done_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/min_drain_scheduler.md
# min_drain_scheduler

Sequential scheduler that drains a batch of up to CHANNEL_COUNT valued requests in ascending-value order, one grant at a time, over a valid/ready handshake. Each cycle it is in SCAN, it finds the minimum-valued pending channel with the existing combinational min_val_less_8x_with_index, registers that channel as the grant, and retires it on handshake. It sits between the per-channel value producers (e.g. cluster-growth candidates) and the single downstream consumer that must serve them smallest-first.

## Interface
- DATA_WIDTH, 8, width of each channel value
- CHANNEL_COUNT, 6, number of channels; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- COUNT_WIDTH, $clog2(CHANNEL_COUNT+1), width of grant_count
- clk  input  1  sole clock; all state updates on posedge
- reset  input  1  synchronous, active-high
- load_valid  input  1  batch offered
- load_ready  output  1  high exactly in IDLE
- load_values  input  DATA_WIDTH*CHANNEL_COUNT  packed channel values
- load_mask  input  CHANNEL_COUNT  per-channel request valid
- grant_valid  output  1  grant offered
- grant_ready  input  1  consumer accepts grant
- grant_index  output  CHANNEL_COUNT  one-hot granted channel
- grant_value  output  DATA_WIDTH  value of granted channel
- grant_count  output  COUNT_WIDTH  grants completed in current batch
- done  output  1  one-cycle pulse, batch fully drained
- flush  input  1  abort batch (only with MIN_DRAIN_FLUSH_EN)

## Operation
- States: IDLE, SCAN, ISSUE, DONE.
- IDLE: load_ready=1. On load_valid, capture load_values into value_reg and load_mask into pending, clear grant_count, go to SCAN.
- SCAN: feed value_reg and pending to the min finder. If pending==0, go to DONE. Otherwise reduce its output_valids to its lowest set bit (tie-break: lowest channel index wins), register it into grant_index and the matching value into grant_value, set grant_valid, and go to ISSUE.
- ISSUE: hold grant_valid/grant_index/grant_value stable until grant_ready. On handshake: pending &= ~grant_index, grant_count+1, grant_valid=0, go to SCAN.
- DONE: done=1 for this single cycle, then go to IDLE. grant_count holds its final value until the next load.
- Equal values are granted in ascending index order. Masked channels are never granted, whatever their value.
- load_valid outside IDLE is ignored (no capture). grant_ready outside ISSUE is ignored.
- Reset (any state, including mid-drain) → IDLE next cycle. pending, value_reg, grant_index, grant_value and grant_count clear to 0. grant_valid and done are 0. The batch is lost.

## Timing
- Reset values: load_ready=1 (IDLE), grant_valid=0, grant_index=0, grant_value=0, grant_count=0, done=0.
- Load handshake at cycle T → SCAN at T+1 → grant_valid at T+2.
- Grant handshake at cycle G → SCAN at G+1 → next grant_valid at G+2. Peak throughput is one grant per 2 cycles.
- After the last grant handshake at G: SCAN at G+1, done at G+2, load_ready at G+3.
- Empty load_mask at T: done at T+2, no grant issued.
- A full batch of N requests with grant_ready tied high completes in 2N+2 cycles from the load handshake to done.

## Configuration
- MIN_DRAIN_FLUSH_EN defined: the flush port exists. flush=1 in SCAN or ISSUE clears pending and grant_valid and goes to IDLE next cycle, with no done pulse. grant_count keeps the number of grants completed before the flush. flush has priority over a simultaneous grant handshake; that grant is not counted. flush in IDLE or DONE is ignored.
- Not defined: no flush port. Once loaded, a batch always drains fully unless reset.

## Structure
- Package min_drain_pkg holds:
  - the state enum typedef (IDLE, SCAN, ISSUE, DONE);
  - the lowest-set-bit one-hot function;
  - default parameter constants.
- One sub-module: an instance of min_val_less_8x_with_index with DATA_WIDTH and CHANNEL_COUNT passed through. Its values input is value_reg and its valids input is pending. No other hierarchy.

## Test plan
- Ascending drain: values ch0..ch5 = 6,5,4,3,2,1, mask 6'b111111, grant_ready=1 → grant_index 6'b100000, 010000, 001000, 000100, 000010, 000001 with grant_value 1..6, every other cycle; done 2 cycles after the 6th handshake; grant_count=6.
- Mask and tie: ch1=ch3=7, ch0=0 but masked, mask 6'b001010 → grant ch1 (6'b000010, value 7), then ch3 (6'b001000), then done; ch0 never granted.
- Empty batch: load_mask=0 at T → done at T+2, grant_valid never high, grant_count=0.
- Backpressure: hold grant_ready low for 3 cycles in ISSUE → grant_valid, grant_index and grant_value stay unchanged, grant_count stays unchanged; the handshake on the 4th cycle retires the channel.
- Reset mid-drain: reset after 2 of 4 grants → next cycle load_ready=1, grant_valid=0, grant_count=0; a new load drains correctly.
- Flush (MIN_DRAIN_FLUSH_EN): flush asserted together with grant_ready during the 3rd grant → IDLE next cycle, no done pulse, grant_count=2.
